// File: rtl/isa_pkg.sv
// Shared ISA definitions for the matrix datapath: register index width,
// default matrix stride, opcodes and the load/store sequencer types.
package isa_pkg;

  localparam int MATRIX_W = 4;
  localparam int STRIDE_W = 32;
  localparam int SBYTES   = 32;

  typedef enum logic {
    LD_M = 1'b0,
    ST_M = 1'b1
  } opcode_t;

  typedef struct packed {
    logic                store;
    logic [MATRIX_W-1:0] md;
    logic [STRIDE_W-1:0] base;
    logic [STRIDE_W-1:0] stride;
  } mls_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } mls_state_t;

endpackage

// File: rtl/matrix_ls_sequencer.sv
// Row sequencer for LD_M / ST_M: issues ROWS memory requests at base + row*stride,
// keeps up to MAX_OUT in flight and writes load responses into the matrix register file.
module matrix_ls_sequencer #(
  parameter int WORD_W     = 32,
  parameter int MATRIX_W   = isa_pkg::MATRIX_W,
  parameter int ROWS       = 4,
  parameter int ROW_W      = 64,
  parameter int DEF_STRIDE = isa_pkg::SBYTES,
  parameter int MAX_OUT    = 2,
  localparam int ROW_CW    = $clog2(ROWS)
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_store_i,
  input  logic [MATRIX_W-1:0] req_md_i,
  input  logic [WORD_W-1:0]   req_base_i,
  input  logic [WORD_W-1:0]   req_stride_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [WORD_W-1:0]   mem_req_addr_o,
  output logic                mem_req_wen_o,
  output logic [ROW_W-1:0]    mem_req_wdata_o,
  input  logic                mem_resp_valid_i,
  input  logic [ROW_W-1:0]    mem_resp_data_i,
  output logic [MATRIX_W-1:0] mat_rd_md_o,
  output logic [ROW_CW-1:0]   mat_rd_row_o,
  input  logic [ROW_W-1:0]    mat_rdata_i,
  output logic                mat_we_o,
  output logic [MATRIX_W-1:0] mat_wr_md_o,
  output logic [ROW_CW-1:0]   mat_wr_row_o,
  output logic [ROW_W-1:0]    mat_wdata_o,
  output logic                busy_o,
  output logic                done_o,
  output isa_pkg::mls_state_t state_o
);
  import isa_pkg::*;

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0]  MAX_OUT_C = OUT_W'(MAX_OUT);
  localparam logic [ROW_CW-1:0] LAST_ROW  = ROW_CW'(ROWS - 1);
  localparam logic [WORD_W-1:0] DEF_STR_C = WORD_W'(DEF_STRIDE);

  mls_state_t          state;
  logic                store_q;
  logic [MATRIX_W-1:0] md_q;
  logic [WORD_W-1:0]   addr_q;
  logic [WORD_W-1:0]   stride_q;
  logic [ROW_CW-1:0]   issue_cnt;
  logic [ROW_CW-1:0]   resp_cnt;
  logic [OUT_W-1:0]    out_cnt;
  logic                done_q;
  logic                issue_hs;
  logic                resp_take;

  // Valid/ready: a transfer happens on a rising edge where both are high; once
  // mem_req_valid_o rises it holds with stable addr/wdata until mem_req_ready_i.
  assign mem_req_valid_o = (state == ISSUE) && (out_cnt < MAX_OUT_C);
  assign issue_hs        = mem_req_valid_o && mem_req_ready_i;
  assign resp_take       = mem_resp_valid_i && (state != IDLE);

  assign req_ready_o     = (state == IDLE);
  assign busy_o          = (state != IDLE);
  assign done_o          = done_q;
  assign state_o         = state;
  assign mem_req_addr_o  = addr_q;
  assign mem_req_wen_o   = store_q;
  assign mem_req_wdata_o = mat_rdata_i;
  assign mat_rd_md_o     = md_q;
  assign mat_rd_row_o    = issue_cnt;
  assign mat_we_o        = resp_take && !store_q;
  assign mat_wr_md_o     = md_q;
  assign mat_wr_row_o    = resp_cnt;
  assign mat_wdata_o     = mem_resp_data_i;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      store_q   <= 1'b0;
      md_q      <= '0;
      addr_q    <= '0;
      stride_q  <= '0;
      issue_cnt <= '0;
      resp_cnt  <= '0;
      out_cnt   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (issue_hs) begin
        addr_q    <= addr_q + stride_q;
        issue_cnt <= issue_cnt + ROW_CW'(1);
      end
      if (resp_take) resp_cnt <= resp_cnt + ROW_CW'(1);
      // A request and a response in the same cycle cancel in the occupancy count.
      unique case ({issue_hs, resp_take})
        2'b10:   out_cnt <= out_cnt + OUT_W'(1);
        2'b01:   out_cnt <= out_cnt - OUT_W'(1);
        default: ;
      endcase
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            store_q   <= req_store_i;
            md_q      <= req_md_i;
            addr_q    <= req_base_i;
            stride_q  <= (req_stride_i == '0) ? DEF_STR_C : req_stride_i;
            issue_cnt <= '0;
            resp_cnt  <= '0;
            out_cnt   <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_hs && issue_cnt == LAST_ROW) state <= DRAIN;
        end
        DRAIN: begin
          if (resp_take && resp_cnt == LAST_ROW) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_ls_sequencer.sv
// Directed bench for matrix_ls_sequencer with an in-order memory responder of
// programmable latency and a combinational matrix read model.
module tb_matrix_ls_sequencer;
  import isa_pkg::*;

  localparam int WORD_W = 32, MATRIX_W = 4, ROWS = 4, ROW_W = 64;
  localparam int DEF_STRIDE = 32, MAX_OUT = 2, ROW_CW = 2;

  logic                CLK = 1'b0;
  logic                nRST = 1'b0;
  logic                req_valid_i = 1'b0;
  logic                req_ready_o;
  logic                req_store_i = 1'b0;
  logic [MATRIX_W-1:0] req_md_i = '0;
  logic [WORD_W-1:0]   req_base_i = '0;
  logic [WORD_W-1:0]   req_stride_i = '0;
  logic                mem_req_valid_o;
  logic                mem_req_ready_i = 1'b1;
  logic [WORD_W-1:0]   mem_req_addr_o;
  logic                mem_req_wen_o;
  logic [ROW_W-1:0]    mem_req_wdata_o;
  logic                mem_resp_valid_i = 1'b0;
  logic [ROW_W-1:0]    mem_resp_data_i = '0;
  logic [MATRIX_W-1:0] mat_rd_md_o;
  logic [ROW_CW-1:0]   mat_rd_row_o;
  logic [ROW_W-1:0]    mat_rdata_i;
  logic                mat_we_o;
  logic [MATRIX_W-1:0] mat_wr_md_o;
  logic [ROW_CW-1:0]   mat_wr_row_o;
  logic [ROW_W-1:0]    mat_wdata_o;
  logic                busy_o;
  logic                done_o;
  mls_state_t          state_o;

  matrix_ls_sequencer #(
    .WORD_W(WORD_W), .MATRIX_W(MATRIX_W), .ROWS(ROWS), .ROW_W(ROW_W),
    .DEF_STRIDE(DEF_STRIDE), .MAX_OUT(MAX_OUT)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_md_i(req_md_i), .req_base_i(req_base_i), .req_stride_i(req_stride_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_wen_o(mem_req_wen_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_data_i(mem_resp_data_i), .mat_rd_md_o(mat_rd_md_o),
    .mat_rd_row_o(mat_rd_row_o), .mat_rdata_i(mat_rdata_i), .mat_we_o(mat_we_o),
    .mat_wr_md_o(mat_wr_md_o), .mat_wr_row_o(mat_wr_row_o), .mat_wdata_o(mat_wdata_o),
    .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
  );

  // Matrix register file read model: row data encodes register and row index.
  assign mat_rdata_i = {16'hCAFE, 12'h000, mat_rd_md_o, 28'h0, 2'b00, mat_rd_row_o};

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int resp_delay = 1;
  logic force_resp = 1'b0;
  int viol = 0;
  int stab_err = 0;
  int done_cnt = 0;

  int               pend_due[$];
  logic [WORD_W-1:0] pend_addr[$];
  logic [WORD_W-1:0] req_addr_q[$];
  logic              req_wen_q[$];
  logic [ROW_W-1:0]  req_wdata_q[$];
  logic [ROW_CW-1:0] req_row_q[$];
  int                req_win_q[$];
  logic [ROW_CW-1:0] we_row_q[$];
  logic [MATRIX_W-1:0] we_md_q[$];
  logic [ROW_W-1:0]  we_data_q[$];
  int                acc_win_q[$];
  int                done_win_q[$];
  logic [WORD_W-1:0] exp_q[$];

  logic              prev_stall = 1'b0;
  logic [WORD_W-1:0] prev_addr = '0;
  logic [ROW_W-1:0]  prev_wdata = '0;
  logic [ROW_CW-1:0] prev_row = '0;

  function automatic logic [ROW_W-1:0] resp_val(input logic [WORD_W-1:0] a);
    return {a, ~a};
  endfunction

  // Responder: drives one response per accepted request after resp_delay cycles.
  always begin
    @(posedge CLK); #1;
    if (mem_resp_valid_i && !force_resp && pend_due.size() > 0) begin
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end
    if (force_resp) begin
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = 64'hDEAD_BEEF_0BAD_F00D;
    end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = resp_val(pend_addr[0]);
    end else begin
      mem_resp_valid_i = 1'b0;
      mem_resp_data_i  = '0;
    end
  end

  // Monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (!nRST) begin
      pend_due.delete();
      pend_addr.delete();
      prev_stall = 1'b0;
    end else begin
      if (req_valid_i && req_ready_o) acc_win_q.push_back(cyc);
      if (mem_req_valid_o && pend_due.size() >= MAX_OUT) viol++;
      if (prev_stall && !(mem_req_valid_o && mem_req_addr_o == prev_addr &&
          mem_req_wdata_o == prev_wdata && mat_rd_row_o == prev_row)) stab_err++;
      prev_stall = mem_req_valid_o && !mem_req_ready_i;
      prev_addr  = mem_req_addr_o;
      prev_wdata = mem_req_wdata_o;
      prev_row   = mat_rd_row_o;
      if (mem_req_valid_o && mem_req_ready_i) begin
        pend_due.push_back(cyc + resp_delay);
        pend_addr.push_back(mem_req_addr_o);
        req_addr_q.push_back(mem_req_addr_o);
        req_wen_q.push_back(mem_req_wen_o);
        req_wdata_q.push_back(mem_req_wdata_o);
        req_row_q.push_back(mat_rd_row_o);
        req_win_q.push_back(cyc);
      end
      if (mat_we_o) begin
        we_row_q.push_back(mat_wr_row_o);
        we_md_q.push_back(mat_wr_md_o);
        we_data_q.push_back(mat_wdata_o);
      end
      if (done_o) begin
        done_cnt++;
        done_win_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic clear_obs();
    req_addr_q.delete(); req_wen_q.delete(); req_wdata_q.delete(); req_row_q.delete();
    req_win_q.delete(); we_row_q.delete(); we_md_q.delete(); we_data_q.delete();
    acc_win_q.delete(); done_win_q.delete(); exp_q.delete();
  endtask

  task automatic submit(input logic st, input logic [3:0] md,
                        input logic [31:0] base, input logic [31:0] stride);
    req_valid_i = 1'b1; req_store_i = st; req_md_i = md;
    req_base_i = base; req_stride_i = stride;
  endtask

  task automatic start_op(input logic st, input logic [3:0] md,
                          input logic [31:0] base, input logic [31:0] stride);
    submit(st, md, base, stride);
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 300) begin tick(); n++; end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout: done_o count %0d, required %0d", name, done_cnt, target);
    end
    tick(); tick();
  endtask

  task automatic test_reset();
    nRST = 1'b0; req_valid_i = 1'b0;
    repeat (3) tick();
    checks++;
    if ({req_ready_o, mem_req_valid_o, mem_req_wen_o, mat_we_o, busy_o, done_o} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 100000",
               {req_ready_o, mem_req_valid_o, mem_req_wen_o, mat_we_o, busy_o, done_o});
    end
    checks++;
    if (mem_req_addr_o !== 32'h0) begin
      errors++; $display("FAIL reset_addr: got %h, required 0", mem_req_addr_o);
    end
    checks++;
    if ({mat_rd_md_o, mat_rd_row_o, mat_wr_md_o, mat_wr_row_o} !== 12'h0) begin
      errors++; $display("FAIL reset_mat_addr: got %h, required 0",
                         {mat_rd_md_o, mat_rd_row_o, mat_wr_md_o, mat_wr_row_o});
    end
    checks++;
    if (state_o !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d, required IDLE", state_o);
    end
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_load();
    int a;
    clear_obs(); resp_delay = 1; mem_req_ready_i = 1'b1;
    exp_q = '{32'h1000, 32'h1020, 32'h1040, 32'h1060};
    start_op(1'b0, 4'h3, 32'h1000, 32'h0);
    wait_done(done_cnt + 1, "load");
    a = acc_win_q[0];
    checks++;
    if (req_addr_q.size() != 4 || we_row_q.size() != 4 || done_win_q.size() != 1) begin
      errors++; $display("FAIL load_counts: reqs %0d writes %0d dones %0d, required 4 4 1",
                         req_addr_q.size(), we_row_q.size(), done_win_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_addr_q[i] !== exp_q[i] || req_wen_q[i] !== 1'b0 || req_win_q[i] !== a + 1 + i) begin
        errors++; $display("FAIL load_req%0d: addr %h wen %b win %0d, required %h 0 %0d",
                           i, req_addr_q[i], req_wen_q[i], req_win_q[i], exp_q[i], a + 1 + i);
      end
      checks++;
      if (we_row_q[i] !== i[1:0] || we_md_q[i] !== 4'h3 || we_data_q[i] !== resp_val(exp_q[i])) begin
        errors++; $display("FAIL load_write%0d: row %0d md %h data %h, required %0d 3 %h",
                           i, we_row_q[i], we_md_q[i], we_data_q[i], i, resp_val(exp_q[i]));
      end
    end
    checks++;
    if (done_win_q[0] !== a + 6) begin
      errors++; $display("FAIL load_done_latency: window %0d, required %0d", done_win_q[0], a + 6);
    end
  endtask

  task automatic test_store();
    logic [ROW_W-1:0] exp_wd;
    clear_obs();
    exp_q = '{32'h1000, 32'h1100, 32'h1200, 32'h1300};
    start_op(1'b1, 4'h5, 32'h1000, 32'h100);
    wait_done(done_cnt + 1, "store");
    for (int i = 0; i < 4; i++) begin
      exp_wd = 64'hCAFE_0005_0000_0000 | 64'(i);
      checks++;
      if (req_addr_q[i] !== exp_q[i] || req_wen_q[i] !== 1'b1 ||
          req_wdata_q[i] !== exp_wd || req_row_q[i] !== i[1:0]) begin
        errors++; $display("FAIL store_req%0d: addr %h wen %b wdata %h row %0d, required %h 1 %h %0d",
                           i, req_addr_q[i], req_wen_q[i], req_wdata_q[i], req_row_q[i],
                           exp_q[i], exp_wd, i);
      end
    end
    checks++;
    if (we_row_q.size() != 0) begin
      errors++; $display("FAIL store_no_write: %0d matrix writes, required 0", we_row_q.size());
    end
  endtask

  task automatic test_backpressure();
    int a;
    int v0;
    clear_obs(); resp_delay = 5; v0 = viol;
    exp_q = '{32'h2000, 32'h2040, 32'h2080, 32'h20C0};
    start_op(1'b0, 4'h7, 32'h2000, 32'h40);
    wait_done(done_cnt + 1, "outstanding");
    a = acc_win_q[0];
    checks++;
    if (viol !== v0) begin
      errors++; $display("FAIL outstanding_limit: %0d cycles valid at limit, required 0", viol - v0);
    end
    checks++;
    if (req_win_q[0] !== a + 1 || req_win_q[1] !== a + 2 || req_win_q[2] !== a + 7 ||
        req_win_q[3] !== a + 8) begin
      errors++; $display("FAIL outstanding_windows: %0d %0d %0d %0d, required %0d %0d %0d %0d",
                         req_win_q[0] - a, req_win_q[1] - a, req_win_q[2] - a, req_win_q[3] - a,
                         1, 2, 7, 8);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_addr_q[i] !== exp_q[i] || we_row_q[i] !== i[1:0]) begin
        errors++; $display("FAIL outstanding_row%0d: addr %h wrow %0d, required %h %0d",
                           i, req_addr_q[i], we_row_q[i], exp_q[i], i);
      end
    end
    checks++;
    if (done_win_q[0] !== a + 14) begin
      errors++; $display("FAIL outstanding_done: window %0d, required %0d", done_win_q[0] - a, 14);
    end
    resp_delay = 1;
  endtask

  task automatic test_stall();
    int a;
    int s0;
    clear_obs(); s0 = stab_err; mem_req_ready_i = 1'b0;
    exp_q = '{32'h3000, 32'h3010, 32'h3020, 32'h3030};
    start_op(1'b1, 4'h2, 32'h3000, 32'h10);
    a = acc_win_q[0];
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mem_req_valid_o !== 1'b1 || busy_o !== 1'b1 || mem_req_addr_o !== 32'h3000 ||
          mem_req_wdata_o !== 64'hCAFE_0002_0000_0000 || mat_rd_row_o !== 2'd0) begin
        errors++; $display("FAIL stall_hold%0d: valid %b busy %b addr %h wdata %h row %0d, required 1 1 3000 cafe000200000000 0",
                           k, mem_req_valid_o, busy_o, mem_req_addr_o, mem_req_wdata_o, mat_rd_row_o);
      end
      tick();
    end
    mem_req_ready_i = 1'b1;
    wait_done(done_cnt + 1, "stall");
    checks++;
    if (stab_err !== s0 || req_win_q[0] !== a + 4) begin
      errors++; $display("FAIL stall_stable: %0d unstable cycles, first req window %0d, required 0 %0d",
                         stab_err - s0, req_win_q[0] - a, 4);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_addr_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_addr%0d: got %h, required %h", i, req_addr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    clear_obs();
    exp_q = '{32'hFFFF_FFE0, 32'h0000_0000, 32'h0000_0020, 32'h0000_0040};
    start_op(1'b0, 4'h6, 32'hFFFF_FFE0, 32'h20);
    wait_done(done_cnt + 1, "wrap");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_addr_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL wrap_addr%0d: got %h, required %h", i, req_addr_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int d0;
    clear_obs(); resp_delay = 3;
    start_op(1'b0, 4'h1, 32'h4000, 32'h0);
    while (state_o !== DRAIN && n < 100) begin tick(); n++; end
    checks++;
    if (state_o !== DRAIN) begin
      errors++; $display("FAIL rst_mid_reach_drain: state %0d, required DRAIN", state_o);
    end
    d0 = done_cnt;
    nRST = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    @(negedge CLK); force_resp = 1'b1;
    @(posedge CLK); #2;
    checks++;
    if ({mat_we_o, req_ready_o, busy_o, mem_req_valid_o, done_o} !== 5'b01000 || state_o !== IDLE) begin
      errors++; $display("FAIL rst_mid_late_resp: we/ready/busy/valid/done %b state %0d, required 01000 IDLE",
                         {mat_we_o, req_ready_o, busy_o, mem_req_valid_o, done_o}, state_o);
    end
    @(negedge CLK); force_resp = 1'b0;
    resp_delay = 1;
    repeat (6) tick();
    checks++;
    if (done_cnt !== d0) begin
      errors++; $display("FAIL rst_mid_no_done: %0d done pulses, required 0", done_cnt - d0);
    end
    clear_obs();
    start_op(1'b0, 4'h9, 32'h5000, 32'h0);
    wait_done(done_cnt + 1, "rst_mid_next");
    checks++;
    if (we_row_q.size() != 4 || req_addr_q[3] !== 32'h5060 || we_md_q[3] !== 4'h9) begin
      errors++; $display("FAIL rst_mid_next_op: writes %0d last addr %h md %h, required 4 5060 9",
                         we_row_q.size(), req_addr_q[3], we_md_q[3]);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int d0;
    clear_obs(); d0 = done_cnt;
    start_op(1'b0, 4'h1, 32'h6000, 32'h0);
    submit(1'b1, 4'h4, 32'h7000, 32'h8);
    while (!req_ready_o && n < 100) begin tick(); n++; end
    tick();
    req_valid_i = 1'b0;
    wait_done(d0 + 2, "b2b");
    checks++;
    if (acc_win_q.size() != 2 || done_win_q.size() != 2 || acc_win_q[1] !== done_win_q[0]) begin
      errors++; $display("FAIL b2b_accept_on_done: accepts %0d dones %0d, accept window %0d, required done window %0d",
                         acc_win_q.size(), done_win_q.size(), acc_win_q[1], done_win_q[0]);
    end
    checks++;
    if (req_win_q[4] !== acc_win_q[1] + 1 || req_addr_q[4] !== 32'h7000 ||
        req_wen_q[4] !== 1'b1 || req_addr_q[7] !== 32'h7018) begin
      errors++; $display("FAIL b2b_second_op: first window %0d addr %h wen %b last addr %h, required %0d 7000 1 7018",
                         req_win_q[4], req_addr_q[4], req_wen_q[4], req_addr_q[7], acc_win_q[1] + 1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_backpressure();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_ls_sequencer.md
# matrix_ls_sequencer

Row sequencer for the matrix load/store instructions (LD_M, ST_M). It takes one decoded matrix memory op and issues ROWS row-sized memory requests at base + row·stride. The stride is set per instruction, with a default of SBYTES when zero, and up to MAX_OUT requests may be outstanding. Load responses are written into the matrix register file. The block sits between decode/dispatch and the data-memory port, generalising the fixed 16-element stride into a run-time-configurable, pipelined sequencer.

## Interface
Parameters:
- WORD_W, 32, address width
- MATRIX_W, 4, matrix register index width
- ROWS, 4, rows per matrix (≥2)
- ROW_W, 64, row data width in bits
- DEF_STRIDE, 32, byte stride used when req_stride_i == 0 (SBYTES)
- MAX_OUT, 2, max outstanding memory requests (1..ROWS)

Ports:
- CLK  in  1  clock. Single clock domain; reset is synchronous and active-low.
- nRST  in  1  synchronous active-low reset
- req_valid_i  in  1  op valid
- req_ready_o  out  1  sequencer can accept an op
- req_store_i  in  1  0 = LD_M, 1 = ST_M
- req_md_i  in  MATRIX_W  matrix register
- req_base_i  in  WORD_W  base byte address
- req_stride_i  in  WORD_W  row stride in bytes (0 → DEF_STRIDE)
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  WORD_W  row address
- mem_req_wen_o  out  1  1 = write
- mem_req_wdata_o  out  ROW_W  store data (= mat_rdata_i)
- mem_resp_valid_i  in  1  one per accepted request, in order
- mem_resp_data_i  in  ROW_W  load row data
- mat_rd_md_o / mat_rd_row_o  out  MATRIX_W / $clog2(ROWS)  combinational read address for store data
- mat_rdata_i  in  ROW_W  combinational read data
- mat_we_o  out  1  matrix row write enable
- mat_wr_md_o / mat_wr_row_o  out  MATRIX_W / $clog2(ROWS)  write address
- mat_wdata_o  out  ROW_W  = mem_resp_data_i
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse on completion

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, latch store, md, and base into addr.
  - Latch stride as req_stride_i, or DEF_STRIDE if it is 0.
  - Clear issue_cnt, resp_cnt, and out_cnt; go to ISSUE.
- ISSUE:
  - mem_req_valid_o = (out_cnt < MAX_OUT).
  - Outputs: addr = current addr, wen = store, row = issue_cnt.
  - On handshake: addr += stride (mod 2^WORD_W, wrap allowed), issue_cnt++, out_cnt++.
  - The handshake with issue_cnt == ROWS−1 moves to DRAIN.
- Response handling (ISSUE and DRAIN):
  - Each mem_resp_valid_i decrements out_cnt and increments resp_cnt.
  - Load ops only: mat_we_o = 1 in the same cycle, with mat_wr_md_o = md and mat_wr_row_o = resp_cnt.
- Simultaneous issue handshake and response: out_cnt is unchanged, and both counters advance.
- DRAIN:
  - The response with resp_cnt == ROWS−1 returns to IDLE.
  - done_o pulses on the following cycle, i.e. the first IDLE cycle.
- Responses arriving in IDLE are ignored (no write, no count change).
- mat_rd_md_o = latched md and mat_rd_row_o = issue_cnt at all times. Store data is therefore presented in the same cycle as its request.
- mem_req_valid_o, once asserted, stays asserted with stable addr/wdata until mem_req_ready_i.

## Timing
- Reset values: all outputs 0 except req_ready_o = 1; state is IDLE; all counters are 0.
- Reset mid-operation returns to IDLE. Outstanding requests are abandoned, and their late responses are ignored.
- Op accepted at cycle t → first mem_req_valid_o at t+1.
- With mem_req_ready_i = 1 and 1-cycle response: ROWS requests issue in ROWS consecutive cycles, and done_o appears 2 cycles after the last request.
- Back-pressure: the MAX_OUT limit gates mem_req_valid_o combinationally from the registered out_cnt. A response in the same cycle does not free a slot until the next cycle.
- A new op can be accepted in the cycle done_o is high.

## Structure
- Shared package (isa_pkg):
  - MATRIX_W, stride/SBYTES (DEF_STRIDE default) and opcode_t LD_M/ST_M already live there.
  - Add a packed mls_req_t struct (store, md, base, stride) and an mls_state_t enum (IDLE, ISSUE, DRAIN).
- No sub-module is needed; the counters and FSM are inline in one module.

## Test plan
- Load, base 0x1000, stride 0, ROWS = 4, memory always ready, 1-cycle response → addresses 0x1000/0x1020/0x1040/0x1060; mat_we_o rows 0..3 in order; one done_o pulse.
- Store, stride 0x100 → addresses 0x1000, 0x1100, …; wen = 1; mem_req_wdata_o equals mat_rdata_i for mat_rd_row_o 0..3; mat_we_o never asserts.
- MAX_OUT = 2, responses delayed 5 cycles → mem_req_valid_o never high while out_cnt == 2; all 4 rows complete.
- mem_req_ready_i held low 3 cycles → addr and wdata are stable throughout; no counter advances.
- Base 0xFFFF_FFE0, stride 0x20 → second address 0x0000_0000 (wrap).
- nRST low during DRAIN, then a late response → idle outputs, mat_we_o = 0, no done_o; the next op completes normally.
